// File: rtl/basic_logic_unit_if.sv
// Handshake bundle for basic_logic_unit: operand channel in, result channel with flags out.
interface basic_logic_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             red_and;
  logic             red_or;
  logic             red_xor;
  logic             zero;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, red_and, red_or, red_xor, zero, txn_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, red_and, red_or, red_xor, zero, txn_count
  );
endinterface

// File: rtl/basic_logic_unit.sv
// Two-stage bitwise logic unit: S1 captures operands, S2 holds the result and its reduction flags.
module basic_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  basic_logic_unit_if.slave   bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic             in_ready;
  logic             s1_load;
  logic             s2_load;
  logic             out_hs;
  logic [WIDTH-1:0] y_calc;

  always_comb begin
    unique case (s1_op_q)
      3'd0:    y_calc = s1_a_q & s1_b_q;
      3'd1:    y_calc = s1_a_q | s1_b_q;
      3'd2:    y_calc = s1_a_q ^ s1_b_q;
      3'd3:    y_calc = ~(s1_a_q & s1_b_q);
      3'd4:    y_calc = ~(s1_a_q | s1_b_q);
      3'd5:    y_calc = ~(s1_a_q ^ s1_b_q);
      3'd6:    y_calc = ~s1_a_q;
      default: y_calc = s1_a_q;
    endcase
  end

  always_comb begin
    // S2 frees up whenever its result is being taken, so in_ready never waits on in_valid
    s2_load  = s1_valid_q && (!out_valid_q || bus.out_ready);
    in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
    s1_load  = bus.in_valid && in_ready;
    out_hs   = out_valid_q && bus.out_ready;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_op_d    = bus.op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    y_d         = y_q;
    red_and_d   = red_and_q;
    red_or_d    = red_or_q;
    red_xor_d   = red_xor_q;
    zero_d      = zero_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      y_d         = y_calc;
      red_and_d   = &y_calc;
      red_or_d    = |y_calc;
      red_xor_d   = ^y_calc;
      zero_d      = (y_calc == '0);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    txn_d = txn_q + CNT_W'(out_hs);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      red_and_q   <= 1'b0;
      red_or_q    <= 1'b0;
      red_xor_q   <= 1'b0;
      zero_q      <= 1'b0;
      txn_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      red_and_q   <= red_and_d;
      red_or_q    <= red_or_d;
      red_xor_q   <= red_xor_d;
      zero_q      <= zero_d;
      txn_q       <= txn_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.red_and   = red_and_q;
  assign bus.red_or    = red_or_q;
  assign bus.red_xor   = red_xor_q;
  assign bus.zero      = zero_q;
  assign bus.txn_count = txn_q;

endmodule
